// File: rtl/ycr1_pipe_mprf_wb_arb_if.sv
// Writeback arbiter bundle: EXU/LSU writeback sources, load-issue tracking,
// hazard query and the registered MPRF write port.
// master = pipeline side (EXU/LSU), slave = arbiter.
interface ycr1_pipe_mprf_wb_arb_if #(
    parameter int AWIDTH   = 5,
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 2
);
    localparam int CW = $clog2(LQ_DEPTH + 1);

    logic              exu_wb_req_i;
    logic [AWIDTH-1:0] exu_wb_addr_i;
    logic [XLEN-1:0]   exu_wb_data_i;
    logic              lsu_wb_req_i;
    logic [AWIDTH-1:0] lsu_wb_addr_i;
    logic [XLEN-1:0]   lsu_wb_data_i;
    logic              lsu_wb_rdy_o;
    logic              ld_issue_i;
    logic [AWIDTH-1:0] ld_rd_i;
    logic [AWIDTH-1:0] rs1_addr_i;
    logic [AWIDTH-1:0] rs2_addr_i;
    logic              rs_hazard_o;
    logic              mprf_w_req_o;
    logic [AWIDTH-1:0] mprf_rd_addr_o;
    logic [XLEN-1:0]   mprf_rd_data_o;
    logic [CW-1:0]     lq_cnt_o;

    modport master (
        output exu_wb_req_i, exu_wb_addr_i, exu_wb_data_i,
        output lsu_wb_req_i, lsu_wb_addr_i, lsu_wb_data_i,
        output ld_issue_i, ld_rd_i, rs1_addr_i, rs2_addr_i,
        input  lsu_wb_rdy_o, rs_hazard_o,
        input  mprf_w_req_o, mprf_rd_addr_o, mprf_rd_data_o, lq_cnt_o
    );

    modport slave (
        input  exu_wb_req_i, exu_wb_addr_i, exu_wb_data_i,
        input  lsu_wb_req_i, lsu_wb_addr_i, lsu_wb_data_i,
        input  ld_issue_i, ld_rd_i, rs1_addr_i, rs2_addr_i,
        output lsu_wb_rdy_o, rs_hazard_o,
        output mprf_w_req_o, mprf_rd_addr_o, mprf_rd_data_o, lq_cnt_o
    );
endinterface

// File: rtl/ycr1_pipe_mprf_wb_arb.sv
// Purpose: arbitrates the single MPRF write port between EXU (never stalls) and LSU load returns.
// Latency: selected write appears on mprf_* 1 cycle after selection; pending-load clear on the MPRF capture edge.
// Backpressure: LSU only, lsu_wb_rdy_o drops when the LQ_DEPTH-entry return queue is full; EXU always accepted.
//
// Ports: clk, rst_n (async, active-low) plus bus (slave modport):
//   exu_wb_*  EXU writeback, lsu_wb_* LSU load return with rdy,
//   ld_issue_i/ld_rd_i mark a load destination pending, rs1/rs2 -> rs_hazard_o,
//   mprf_w_req_o/mprf_rd_addr_o/mprf_rd_data_o registered write port, lq_cnt_o queue occupancy.
module ycr1_pipe_mprf_wb_arb #(
    parameter int AWIDTH   = 5,
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    ycr1_pipe_mprf_wb_arb_if.slave bus
);
    localparam int NREG = 2 ** AWIDTH;
    localparam int PW   = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int CW   = $clog2(LQ_DEPTH + 1);

    // return queue (circular buffer; validity is implied by cnt)
    logic [AWIDTH-1:0] lq_addr [LQ_DEPTH];
    logic [XLEN-1:0]   lq_data [LQ_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;

    // registered output stage
    logic              out_req;
    logic              out_src_lsu;
    logic [AWIDTH-1:0] out_addr;
    logic [XLEN-1:0]   out_data;

    // pending-load scoreboard, bit 0 never set
    logic [NREG-1:0]   sb;
    logic [NREG-1:0]   sb_nxt;

    logic              lq_rdy;
    logic              lq_nempty;
    logic              exu_sel;
    logic              lsu_acc;
    logic              lsu_nz;
    logic              pop;
    logic              bypass;
    logic              push;
    logic              clr_hit;

    logic              sel_vld;
    logic              sel_lsu;
    logic [AWIDTH-1:0] sel_addr;
    logic [XLEN-1:0]   sel_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(LQ_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ready depends only on the registered count, so EXU activity never
    // combinationally reaches the LSU handshake.
    assign lq_rdy    = (cnt < CW'(LQ_DEPTH));
    assign lq_nempty = (cnt != '0);
    assign exu_sel   = bus.exu_wb_req_i && (bus.exu_wb_addr_i != '0);
    assign lsu_acc   = bus.lsu_wb_req_i && lq_rdy;
    assign lsu_nz    = (bus.lsu_wb_addr_i != '0);
    assign pop       = !exu_sel && lq_nempty;
    // Bypass only with an empty queue keeps LSU returns in arrival order.
    assign bypass    = !exu_sel && !lq_nempty && lsu_acc && lsu_nz;
    // x0 returns are accepted but dropped.
    assign push      = lsu_acc && lsu_nz && !bypass;
    assign clr_hit   = out_req && out_src_lsu && (out_addr == bus.ld_rd_i);

    always_comb begin
        sel_vld  = 1'b0;
        sel_lsu  = 1'b0;
        sel_addr = out_addr;
        sel_data = out_data;
        if (exu_sel) begin
            sel_vld  = 1'b1;
            sel_addr = bus.exu_wb_addr_i;
            sel_data = bus.exu_wb_data_i;
        end else if (lq_nempty) begin
            sel_vld  = 1'b1;
            sel_lsu  = 1'b1;
            sel_addr = lq_addr[rd_ptr];
            sel_data = lq_data[rd_ptr];
        end else if (bypass) begin
            sel_vld  = 1'b1;
            sel_lsu  = 1'b1;
            sel_addr = bus.lsu_wb_addr_i;
            sel_data = bus.lsu_wb_data_i;
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop) begin
            cnt_nxt = cnt + CW'(1);
        end else if (pop && !push) begin
            cnt_nxt = cnt - CW'(1);
        end
    end

    // Clear when the LSU write is being captured by the MPRF; a load issued to
    // the same register on that edge is newer, so the set is applied last.
    always_comb begin
        sb_nxt = sb;
        if (out_req && out_src_lsu) begin
            sb_nxt[out_addr] = 1'b0;
        end
        if (bus.ld_issue_i && (bus.ld_rd_i != '0)) begin
            sb_nxt[bus.ld_rd_i] = 1'b1;
        end
        sb_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            sb          <= '0;
            out_req     <= 1'b0;
            out_src_lsu <= 1'b0;
            out_addr    <= '0;
            out_data    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            cnt         <= cnt_nxt;
            sb          <= sb_nxt;
            out_req     <= sel_vld;
            out_src_lsu <= sel_lsu;
            out_addr    <= sel_addr;
            out_data    <= sel_data;
        end
    end

    // Queue storage needs no reset: entries are only read when cnt says valid.
    always_ff @(posedge clk) begin
        if (push) begin
            lq_addr[wr_ptr] <= bus.lsu_wb_addr_i;
            lq_data[wr_ptr] <= bus.lsu_wb_data_i;
        end
    end

    assign bus.lsu_wb_rdy_o   = lq_rdy;
    assign bus.lq_cnt_o       = cnt;
    assign bus.mprf_w_req_o   = out_req;
    assign bus.mprf_rd_addr_o = out_addr;
    assign bus.mprf_rd_data_o = out_data;
    assign bus.rs_hazard_o    = sb[bus.rs1_addr_i] | sb[bus.rs2_addr_i];

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            if (exu_sel) begin
                assert (!sb[bus.exu_wb_addr_i])
                else $error("EXU write to x%0d while a load to it is pending", bus.exu_wb_addr_i);
            end
            if (bus.ld_issue_i && (bus.ld_rd_i != '0)) begin
                assert (!sb[bus.ld_rd_i] || clr_hit)
                else $error("load issued to x%0d which already has a load pending", bus.ld_rd_i);
            end
            if (lsu_acc && lsu_nz) begin
                assert (sb[bus.lsu_wb_addr_i])
                else $error("LSU return to x%0d which has no load pending", bus.lsu_wb_addr_i);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ycr1_pipe_mprf_wb_arb.sv
// Bench for the MPRF writeback arbiter: directed scenarios followed by a
// constrained-random phase, all checked against a queue-based reference model.
module tb_ycr1_pipe_mprf_wb_arb;
    localparam int AW  = 5;
    localparam int XL  = 32;
    localparam int LQD = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ycr1_pipe_mprf_wb_arb_if #(.AWIDTH(AW), .XLEN(XL), .LQ_DEPTH(LQD)) bus ();

    ycr1_pipe_mprf_wb_arb #(.AWIDTH(AW), .XLEN(XL), .LQ_DEPTH(LQD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [XL-1:0] d;
    } ent_t;

    // reference model state
    ent_t          mq[$];
    logic          m_req;
    logic          m_src;
    logic [AW-1:0] m_addr;
    logic [XL-1:0] m_data;
    logic [31:0]   pend;
    logic          taken;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_req  = 1'b0;
        m_src  = 1'b0;
        m_addr = '0;
        m_data = '0;
        pend   = '0;
        taken  = 1'b0;
    endtask

    task automatic idle();
        bus.exu_wb_req_i = 1'b0;
        bus.lsu_wb_req_i = 1'b0;
        bus.ld_issue_i   = 1'b0;
    endtask

    task automatic drive_lsu(input logic [AW-1:0] a, input logic [XL-1:0] d);
        bus.lsu_wb_req_i  = 1'b1;
        bus.lsu_wb_addr_i = a;
        bus.lsu_wb_data_i = d;
    endtask

    task automatic drive_exu(input logic [AW-1:0] a, input logic [XL-1:0] d);
        bus.exu_wb_req_i  = 1'b1;
        bus.exu_wb_addr_i = a;
        bus.exu_wb_data_i = d;
    endtask

    // One clock: predict from the writeback rules, advance, compare.
    task automatic cycle();
        logic          rdy;
        logic          acc;
        logic          exu_w;
        logic          byp;
        logic          n_req;
        logic          n_src;
        logic [AW-1:0] n_addr;
        logic [XL-1:0] n_data;
        logic          exp_haz;
        ent_t          e;
        rdy = (mq.size() < LQD);
        chk("lsu_rdy", bus.lsu_wb_rdy_o, rdy);
        acc    = bus.lsu_wb_req_i && rdy;
        exu_w  = bus.exu_wb_req_i && (bus.exu_wb_addr_i != 0);
        byp    = 1'b0;
        n_req  = 1'b0;
        n_src  = 1'b0;
        n_addr = m_addr;
        n_data = m_data;
        if (exu_w) begin
            n_req = 1'b1; n_addr = bus.exu_wb_addr_i; n_data = bus.exu_wb_data_i;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            n_req = 1'b1; n_src = 1'b1; n_addr = e.a; n_data = e.d;
        end else if (acc && bus.lsu_wb_addr_i != 0) begin
            byp = 1'b1;
            n_req = 1'b1; n_src = 1'b1; n_addr = bus.lsu_wb_addr_i; n_data = bus.lsu_wb_data_i;
        end
        if (acc && bus.lsu_wb_addr_i != 0 && !byp) begin
            e.a = bus.lsu_wb_addr_i;
            e.d = bus.lsu_wb_data_i;
            mq.push_back(e);
        end
        if (m_req && m_src) pend[m_addr] = 1'b0;
        if (bus.ld_issue_i && bus.ld_rd_i != 0) pend[bus.ld_rd_i] = 1'b1;
        taken = acc;
        @(posedge clk);
        #1;
        m_req = n_req; m_src = n_src; m_addr = n_addr; m_data = n_data;
        chk("w_req", bus.mprf_w_req_o, m_req);
        chk("w_addr", bus.mprf_rd_addr_o, m_addr);
        chk("w_data", bus.mprf_rd_data_o, m_data);
        chk("lq_cnt", bus.lq_cnt_o, mq.size());
        exp_haz = pend[bus.rs1_addr_i] | pend[bus.rs2_addr_i];
        chk("hazard", bus.rs_hazard_o, exp_haz);
    endtask

    function automatic logic [AW-1:0] pick_free();
        logic [AW-1:0] a;
        for (int k = 0; k < 16; k++) begin
            a = AW'($urandom_range(1, 31));
            if (!pend[a]) return a;
        end
        return '0;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] got[$];
        int            outq[$];
        logic          lsu_busy;
        logic [AW-1:0] r;
        int            idx;

        rst_n = 1'b0;
        idle();
        bus.exu_wb_addr_i = '0; bus.exu_wb_data_i = '0;
        bus.lsu_wb_addr_i = '0; bus.lsu_wb_data_i = '0;
        bus.ld_rd_i = '0; bus.rs1_addr_i = '0; bus.rs2_addr_i = '0;
        model_reset();
        #2;
        chk("rst_req", bus.mprf_w_req_o, 0);
        chk("rst_addr", bus.mprf_rd_addr_o, 0);
        chk("rst_data", bus.mprf_rd_data_o, 0);
        chk("rst_cnt", bus.lq_cnt_o, 0);
        chk("rst_rdy", bus.lsu_wb_rdy_o, 1);
        chk("rst_haz", bus.rs_hazard_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // EXU only
        drive_exu(5, 32'hA5A5_0001);
        cycle();
        chk("exu_req", bus.mprf_w_req_o, 1);
        chk("exu_addr", bus.mprf_rd_addr_o, 5);
        chk("exu_data", bus.mprf_rd_data_o, 32'hA5A5_0001);
        chk("exu_cnt", bus.lq_cnt_o, 0);
        idle();
        cycle();
        chk("exu_idle_req", bus.mprf_w_req_o, 0);

        // LSU bypass with hazard on rs1
        bus.rs1_addr_i = 7;
        bus.ld_issue_i = 1'b1; bus.ld_rd_i = 7;
        cycle();
        chk("byp_haz_pend", bus.rs_hazard_o, 1);
        idle();
        drive_lsu(7, 32'h1234);
        cycle();
        chk("byp_req", bus.mprf_w_req_o, 1);
        chk("byp_addr", bus.mprf_rd_addr_o, 7);
        chk("byp_data", bus.mprf_rd_data_o, 32'h1234);
        chk("byp_haz_held", bus.rs_hazard_o, 1);
        idle();
        cycle();
        chk("byp_haz_clr", bus.rs_hazard_o, 0);
        bus.rs1_addr_i = 0;

        // Collision: EXU wins, LSU queued
        bus.ld_issue_i = 1'b1; bus.ld_rd_i = 9;
        cycle();
        idle();
        drive_exu(3, 32'h3333);
        drive_lsu(9, 32'h9999);
        cycle();
        chk("col_exu_addr", bus.mprf_rd_addr_o, 3);
        chk("col_cnt1", bus.lq_cnt_o, 1);
        idle();
        cycle();
        chk("col_lsu_addr", bus.mprf_rd_addr_o, 9);
        chk("col_lsu_data", bus.mprf_rd_data_o, 32'h9999);
        chk("col_cnt0", bus.lq_cnt_o, 0);
        cycle();

        // Backpressure: queue fills while EXU streams
        for (int i = 0; i < 3; i++) begin
            bus.ld_issue_i = 1'b1; bus.ld_rd_i = AW'(10 + i);
            cycle();
        end
        idle();
        idx = 0;
        drive_lsu(10, $urandom);
        for (int i = 0; i < 4; i++) begin
            drive_exu(AW'(13 + i), $urandom);
            if (i == 3) chk("bp_rdy_low", bus.lsu_wb_rdy_o, 0);
            cycle();
            if (taken) begin
                idx++;
                if (idx < 3) drive_lsu(AW'(10 + idx), $urandom);
                else bus.lsu_wb_req_i = 1'b0;
            end
            if (i == 1) chk("bp_cnt_full", bus.lq_cnt_o, 2);
        end
        bus.exu_wb_req_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (bus.mprf_w_req_o) got.push_back(bus.mprf_rd_addr_o);
            if (taken) begin
                idx++;
                if (idx < 3) drive_lsu(AW'(10 + idx), $urandom);
                else bus.lsu_wb_req_i = 1'b0;
            end
        end
        chk("bp_nwrites", got.size(), 3);
        for (int i = 0; i < got.size() && i < 3; i++) chk("bp_order", got[i], 10 + i);

        // Set/clear race on x4
        bus.ld_issue_i = 1'b1; bus.ld_rd_i = 4;
        cycle();
        idle();
        drive_lsu(4, 32'h4444);
        cycle();
        idle();
        bus.ld_issue_i = 1'b1; bus.ld_rd_i = 4; bus.rs2_addr_i = 4;
        cycle();
        chk("race_haz", bus.rs_hazard_o, 1);
        idle();
        drive_lsu(4, 32'h4445);
        cycle();
        idle();
        cycle();
        cycle();
        chk("race_done_haz", bus.rs_hazard_o, 0);
        bus.rs2_addr_i = 0;

        // x0 writes are dropped
        drive_exu(0, 32'hDEAD);
        cycle();
        chk("x0_exu_req", bus.mprf_w_req_o, 0);
        idle();
        drive_lsu(0, 32'hBEEF);
        cycle();
        chk("x0_lsu_req", bus.mprf_w_req_o, 0);
        chk("x0_lsu_cnt", bus.lq_cnt_o, 0);
        drive_exu(0, 32'h1);
        cycle();
        chk("x0_both_req", bus.mprf_w_req_o, 0);
        idle();

        // Async reset with two queued entries
        bus.rs1_addr_i = 20; bus.rs2_addr_i = 21;
        bus.ld_issue_i = 1'b1; bus.ld_rd_i = 20;
        cycle();
        bus.ld_rd_i = 21;
        cycle();
        idle();
        drive_exu(1, $urandom);
        drive_lsu(20, $urandom);
        cycle();
        drive_exu(2, $urandom);
        drive_lsu(21, $urandom);
        cycle();
        chk("rst_pre_cnt", bus.lq_cnt_o, 2);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mrst_cnt", bus.lq_cnt_o, 0);
        chk("mrst_req", bus.mprf_w_req_o, 0);
        chk("mrst_haz", bus.rs_hazard_o, 0);
        chk("mrst_rdy", bus.lsu_wb_rdy_o, 1);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("post_rst_req", bus.mprf_w_req_o, 0);
        cycle();
        chk("post_rst_req2", bus.mprf_w_req_o, 0);

        // Constrained random traffic
        lsu_busy = 1'b0;
        taken = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (lsu_busy && taken) lsu_busy = 1'b0;
            if (!lsu_busy && outq.size() > 0 && $urandom_range(0, 2) != 0) begin
                drive_lsu(AW'(outq.pop_front()), $urandom);
                lsu_busy = 1'b1;
            end else if (!lsu_busy && $urandom_range(0, 15) == 0) begin
                drive_lsu(0, $urandom);
                lsu_busy = 1'b1;
            end
            bus.lsu_wb_req_i = lsu_busy;
            bus.exu_wb_req_i = 1'b0;
            if ($urandom_range(0, 1) == 1) drive_exu(pick_free(), $urandom);
            bus.ld_issue_i = 1'b0;
            if (outq.size() < 6 && $urandom_range(0, 3) == 0) begin
                r = pick_free();
                if (r != 0 && !(bus.exu_wb_req_i && bus.exu_wb_addr_i == r)) begin
                    bus.ld_issue_i = 1'b1;
                    bus.ld_rd_i = r;
                    outq.push_back(int'(r));
                end
            end
            bus.rs1_addr_i = AW'($urandom_range(0, 31));
            bus.rs2_addr_i = AW'($urandom_range(0, 31));
            cycle();
        end

        // Drain everything outstanding
        bus.exu_wb_req_i = 1'b0;
        bus.ld_issue_i = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (lsu_busy && taken) lsu_busy = 1'b0;
            if (!lsu_busy && outq.size() > 0) begin
                drive_lsu(AW'(outq.pop_front()), $urandom);
                lsu_busy = 1'b1;
            end
            bus.lsu_wb_req_i = lsu_busy;
            if (!lsu_busy && outq.size() == 0 && mq.size() == 0 && pend == 0 && !m_req) break;
            cycle();
        end
        chk("drain_cnt", bus.lq_cnt_o, mq.size());
        chk("drain_pend", pend, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
